// File: rtl/alarm_ctrl_pkg.sv
// Shared types for the alarm clock mode controller: FSM state encoding,
// counter field indices and small state-decoding helpers.
package alarm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN         = 3'd0,
        ST_SET_CLK_HR  = 3'd1,
        ST_SET_CLK_MIN = 3'd2,
        ST_SET_ALM_HR  = 3'd3,
        ST_SET_ALM_MIN = 3'd4,
        ST_RING        = 3'd5,
        ST_SNOOZE      = 3'd6
    } state_t;

    localparam int FLD_CLK_MIN = 0;
    localparam int FLD_CLK_HR  = 1;
    localparam int FLD_ALM_MIN = 2;
    localparam int FLD_ALM_HR  = 3;
    localparam int NUM_FLD     = 4;

    function automatic logic is_set(input state_t s);
        return s inside {ST_SET_CLK_HR, ST_SET_CLK_MIN, ST_SET_ALM_HR, ST_SET_ALM_MIN};
    endfunction

    function automatic logic [1:0] field_of(input state_t s);
        case (s)
            ST_SET_CLK_HR:  return 2'(FLD_CLK_HR);
            ST_SET_CLK_MIN: return 2'(FLD_CLK_MIN);
            ST_SET_ALM_HR:  return 2'(FLD_ALM_HR);
            default:        return 2'(FLD_ALM_MIN);
        endcase
    endfunction

    // The btn_mode walk through the setting states, ending back in RUN.
    function automatic state_t next_set(input state_t s);
        case (s)
            ST_SET_CLK_HR:  return ST_SET_CLK_MIN;
            ST_SET_CLK_MIN: return ST_SET_ALM_HR;
            ST_SET_ALM_HR:  return ST_SET_ALM_MIN;
            default:        return ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_tick_counter.sv
// Loadable down-counter of tick pulses. done is high in the cycle the tick
// that brings the count from 1 to 0 is presented.
module ctrl_tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (tick && count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign done = tick && (count_reg == W'(1));

endmodule

// File: rtl/alarm_mode_ctrl.sv
// Alarm clock mode controller: RUN / time-setting / RING state machine
// driving the display counters. Optional snooze under ALARM_SNOOZE_EN.
module alarm_mode_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int TIMEOUT_S  = 30,
    parameter int RING_S     = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       tick_1min,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       alarm_on,
    input  logic       alarm_match,
    output logic [3:0] inc,
    output logic [3:0] dec,
    output logic       sec_clr,
    output logic       run_en,
    output logic       blink,
    output logic       buzzer,
    output logic [2:0] state
);

    localparam int MAX_A = (TIMEOUT_S > RING_S) ? TIMEOUT_S : RING_S;
    localparam int MAX_T = (MAX_A > SNOOZE_MIN) ? MAX_A : SNOOZE_MIN;
    localparam int CW    = $clog2(MAX_T + 1);

    state_t         state_reg, state_next;
    logic [3:0]     inc_reg, inc_next, dec_reg, dec_next;
    logic           sec_clr_reg, sec_clr_next;
    logic           blink_reg, blink_next;
    logic           match_reg;
    logic           any_btn, set_st, match_rise;
    logic           load, cnt_tick, done;
    logic [CW-1:0]  load_val;

    assign any_btn    = btn_mode | btn_up | btn_down;
    assign set_st     = is_set(state_reg);
    assign match_rise = alarm_match & ~match_reg;
    assign cnt_tick   = (state_reg == ST_SNOOZE) ? tick_1min : tick_1hz;

    always_comb begin
        state_next = state_reg;
        inc_next   = '0;
        dec_next   = '0;
        case (state_reg)
            ST_RUN: begin
                if (btn_mode)                    state_next = ST_SET_CLK_HR;
                else if (alarm_on && match_rise) state_next = ST_RING;
            end
            ST_SET_CLK_HR, ST_SET_CLK_MIN, ST_SET_ALM_HR, ST_SET_ALM_MIN: begin
                if (btn_mode)                state_next = next_set(state_reg);
                else if (!any_btn && done)   state_next = ST_RUN;
                // Conflicting up+down, or either alongside mode, is dropped.
                if (!btn_mode && (btn_up ^ btn_down)) begin
                    inc_next[field_of(state_reg)] = btn_up;
                    dec_next[field_of(state_reg)] = btn_down;
                end
            end
            ST_RING: begin
                if (!alarm_on || btn_mode) state_next = ST_RUN;
`ifdef ALARM_SNOOZE_EN
                else if (btn_up)           state_next = ST_SNOOZE;
`endif
                else if (done)             state_next = ST_RUN;
            end
            ST_SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
                if (!alarm_on || btn_mode) state_next = ST_RUN;
                else if (done)             state_next = ST_RING;
`else
                state_next = ST_RUN;
`endif
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        sec_clr_next = (state_reg == ST_SET_CLK_MIN) && (state_next != ST_SET_CLK_MIN);
        if (state_next != state_reg || !set_st) blink_next = 1'b0;
        else if (tick_1hz)                      blink_next = ~blink_reg;
        else                                    blink_next = blink_reg;
        // One counter serves all timing: reload on every state entry and on
        // any button activity while setting.
        load = (state_next != state_reg) || (set_st && any_btn);
        case (state_next)
            ST_RING:   load_val = CW'(RING_S);
            ST_SNOOZE: load_val = CW'(SNOOZE_MIN);
            default:   load_val = CW'(TIMEOUT_S);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_RUN;
            inc_reg     <= '0;
            dec_reg     <= '0;
            sec_clr_reg <= 1'b0;
            blink_reg   <= 1'b0;
            match_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            inc_reg     <= inc_next;
            dec_reg     <= dec_next;
            sec_clr_reg <= sec_clr_next;
            blink_reg   <= blink_next;
            match_reg   <= alarm_match;
        end
    end

    ctrl_tick_counter #(.W(CW)) u_tick_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .tick     (cnt_tick),
        .done     (done)
    );

    assign inc     = inc_reg;
    assign dec     = dec_reg;
    assign sec_clr = sec_clr_reg;
    assign blink   = blink_reg;
    assign run_en  = ~set_st;
    assign buzzer  = (state_reg == ST_RING);
    assign state   = state_reg;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Scoreboard bench for alarm_mode_ctrl: stimulus queues expected inc/dec/
// sec_clr pulses with their cycle, a monitor compares each pulse seen.
module tb_alarm_mode_ctrl;
    import alarm_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz, tick_1min, btn_mode, btn_up, btn_down;
    logic       alarm_on, alarm_match;
    logic [3:0] inc, dec;
    logic       sec_clr, run_en, blink, buzzer;
    logic [2:0] state;

    alarm_mode_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .tick_1min   (tick_1min),
        .btn_mode    (btn_mode),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .alarm_on    (alarm_on),
        .alarm_match (alarm_match),
        .inc         (inc),
        .dec         (dec),
        .sec_clr     (sec_clr),
        .run_en      (run_en),
        .blink       (blink),
        .buzzer      (buzzer),
        .state       (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] inc;
        logic [3:0] dec;
        logic       sc;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Expected pulse appears right after the edge that samples the button.
    task automatic expect_pulse(input logic [3:0] i, input logic [3:0] d, input logic s);
        exp_t e;
        e.inc = i; e.dec = d; e.sc = s; e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset && (inc != 4'b0 || dec != 4'b0 || sec_clr)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected cyc=%0d actual inc=%b dec=%b sec_clr=%b required none",
                         cyc, inc, dec, sec_clr);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (inc !== e.inc || dec !== e.dec || sec_clr !== e.sc || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse actual inc=%b dec=%b sec_clr=%b cyc=%0d required inc=%b dec=%b sec_clr=%b cyc=%0d",
                             inc, dec, sec_clr, cyc, e.inc, e.dec, e.sc, e.cyc);
                end else begin
                    $display("pulse ok cyc=%0d inc=%b dec=%b sec_clr=%b", cyc, inc, dec, sec_clr);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
        end else begin
            $display("check ok %s = %0d", name, act);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic m, input logic u, input logic d,
                         input logic h, input logic mi);
        btn_mode = m; btn_up = u; btn_down = d; tick_1hz = h; tick_1min = mi;
        @(posedge clk);
        #1;
        btn_mode = 0; btn_up = 0; btn_down = 0; tick_1hz = 0; tick_1min = 0;
    endtask

    task automatic enter_ring();
        alarm_match = 0;
        idle(1);
        alarm_match = 1;
        idle(1);
        chk("ring_entry_state", int'(state), int'(ST_RING));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; tick_1hz = 0; tick_1min = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
        alarm_on = 0; alarm_match = 0;
        idle(2);
        chk("reset_state", int'(state), int'(ST_RUN));
        chk("reset_run_en", int'(run_en), 1);
        chk("reset_buzzer", int'(buzzer), 0);
        chk("reset_blink", int'(blink), 0);
        chk("reset_inc_dec", int'({inc, dec, sec_clr}), 0);
        reset = 0;
        idle(1);

        // Clock-hour setting: three up pulses and one down pulse.
        pulse(1, 0, 0, 0, 0);
        chk("set_clk_hr_state", int'(state), int'(ST_SET_CLK_HR));
        chk("set_run_en", int'(run_en), 0);
        for (int i = 0; i < 3; i++) begin
            expect_pulse(4'b0010, 4'b0000, 1'b0);
            pulse(0, 1, 0, 0, 0);
            idle(1);
        end
        expect_pulse(4'b0000, 4'b0010, 1'b0);
        pulse(0, 0, 1, 0, 0);

        // Clock-minute: conflicting buttons dropped, exit clears seconds.
        pulse(1, 0, 0, 0, 0);
        chk("set_clk_min_state", int'(state), int'(ST_SET_CLK_MIN));
        pulse(0, 1, 1, 0, 0);
        idle(1);
        expect_pulse(4'b0001, 4'b0000, 1'b0);
        pulse(0, 1, 0, 0, 0);
        expect_pulse(4'b0000, 4'b0000, 1'b1);
        pulse(1, 0, 0, 0, 0);
        chk("set_alm_hr_state", int'(state), int'(ST_SET_ALM_HR));
        pulse(1, 1, 0, 0, 0);
        chk("mode_with_up_state", int'(state), int'(ST_SET_ALM_MIN));
        chk("blink_after_change", int'(blink), 0);

        // Timeout restart by a button in alarm-minute setting.
        pulse(0, 0, 0, 1, 0);
        chk("blink_toggle", int'(blink), 1);
        repeat (28) pulse(0, 0, 0, 1, 0);
        expect_pulse(4'b0000, 4'b0100, 1'b0);
        pulse(0, 0, 1, 0, 0);
        repeat (29) pulse(0, 0, 0, 1, 0);
        chk("timeout_restart_state", int'(state), int'(ST_SET_ALM_MIN));
        pulse(0, 0, 0, 1, 0);
        chk("timeout_state", int'(state), int'(ST_RUN));
        chk("timeout_blink", int'(blink), 0);
        chk("timeout_run_en", int'(run_en), 1);

        // Timeout out of clock-minute also clears seconds.
        pulse(1, 0, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            if (i == 29) expect_pulse(4'b0000, 4'b0000, 1'b1);
            pulse(0, 0, 0, 1, 0);
        end
        chk("clk_min_timeout_state", int'(state), int'(ST_RUN));

        // Ringing: auto stop after RING_S seconds, held match does not re-ring.
        alarm_on = 1;
        enter_ring();
        chk("ring_buzzer", int'(buzzer), 1);
        chk("ring_run_en", int'(run_en), 1);
        repeat (59) pulse(0, 0, 0, 1, 0);
        chk("ring_59_state", int'(state), int'(ST_RING));
        pulse(0, 0, 0, 1, 0);
        chk("ring_60_state", int'(state), int'(ST_RUN));
        chk("ring_stop_buzzer", int'(buzzer), 0);
        idle(5);
        chk("no_retrigger_state", int'(state), int'(ST_RUN));

        enter_ring();
        pulse(1, 0, 0, 0, 0);
        chk("ring_mode_stop", int'(state), int'(ST_RUN));

        enter_ring();
        alarm_on = 0;
        pulse(0, 1, 0, 0, 0);
        chk("ring_alarm_off", int'(state), int'(ST_RUN));
        alarm_on = 1;

`ifdef ALARM_SNOOZE_EN
        enter_ring();
        pulse(0, 1, 0, 0, 0);
        chk("snooze_state", int'(state), int'(ST_SNOOZE));
        chk("snooze_buzzer", int'(buzzer), 0);
        repeat (4) pulse(0, 0, 0, 0, 1);
        chk("snooze_4min_state", int'(state), int'(ST_SNOOZE));
        pulse(0, 0, 0, 0, 1);
        chk("snooze_rering_state", int'(state), int'(ST_RING));
        alarm_on = 0;
        idle(1);
        chk("snooze_alarm_off", int'(state), int'(ST_RUN));
        alarm_on = 1;
`else
        enter_ring();
        pulse(0, 1, 0, 0, 0);
        chk("ring_up_ignored", int'(state), int'(ST_RING));
        pulse(1, 0, 0, 0, 0);
        chk("ring_mode_stop2", int'(state), int'(ST_RUN));
`endif

        // Asynchronous reset mid-RING.
        enter_ring();
        #2;
        reset = 1;
        alarm_match = 0;
        #1;
        chk("async_reset_ring_state", int'(state), int'(ST_RUN));
        chk("async_reset_ring_buzzer", int'(buzzer), 0);
        idle(1);
        reset = 0;
        idle(1);

        // Asynchronous reset mid-SET swallows a pending button.
        pulse(1, 0, 0, 0, 0);
        chk("pre_reset_set_state", int'(state), int'(ST_SET_CLK_HR));
        btn_up = 1;
        #2;
        reset = 1;
        #1;
        chk("async_reset_set_state", int'(state), int'(ST_RUN));
        @(posedge clk);
        #1;
        btn_up = 0;
        chk("reset_no_inc", int'(inc), 0);
        reset = 0;
        idle(2);
        chk("post_reset_state", int'(state), int'(ST_RUN));

        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
